ct_hpcp_evt_cnt: RTL and testbench

//  Per-counter event accumulator of the HPCP, directly downstream of the privilege-gated counter-interrupt-enable register.
//  - Stages event increments for one cycle, then accumulates them.
//  - Detects wrap into a sticky overflow flag.
//  - Raises an overflow interrupt request, gated by cntinten_x, with a req/ack handshake toward the interrupt collector.

---
 rtl/ct_hpcp_pkg.sv | 15 +
 rtl/ct_hpcp_evt_cnt_if.sv | 31 +++
 rtl/ct_hpcp_int_fsm.sv | 50 +++++
 rtl/ct_hpcp_evt_cnt.sv | 69 ++++++
 tb/tb_ct_hpcp_evt_cnt.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/ct_hpcp_pkg.sv
// Shared definitions for the HPCP event-counter slice.
// Holds the interrupt FSM encoding and the default counter geometry.
package ct_hpcp_pkg;

    localparam int unsigned CNT_WIDTH_DFLT = 48;
    localparam int unsigned INC_WIDTH_DFLT = 2;

    // 2'b11 is unused and treated as IDLE by the FSM.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PEND     = 2'b01,
        WAIT_CLR = 2'b10
    } int_state_e;

endpackage

// File: rtl/ct_hpcp_evt_cnt_if.sv
// Signal bundle between a per-counter event accumulator and its surroundings:
// event inputs, CSR write path and the overflow interrupt handshake.
interface ct_hpcp_evt_cnt_if
    import ct_hpcp_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DFLT,
    parameter int unsigned INC_WIDTH = INC_WIDTH_DFLT
);

    logic                 cnt_en_x;
    logic [INC_WIDTH-1:0] evt_inc_x;
    logic                 cntinten_x;
    logic                 cnt_wen_x;
    logic                 ovf_wen_x;
    logic [CNT_WIDTH-1:0] hpcp_wdata_x;
    logic                 int_ack_x;
    logic [CNT_WIDTH-1:0] cnt_value_x;
    logic                 cnt_ovf_x;
    logic                 int_req_x;

    modport master (
        output cnt_en_x, evt_inc_x, cntinten_x, cnt_wen_x, ovf_wen_x, hpcp_wdata_x, int_ack_x,
        input  cnt_value_x, cnt_ovf_x, int_req_x
    );

    modport slave (
        input  cnt_en_x, evt_inc_x, cntinten_x, cnt_wen_x, ovf_wen_x, hpcp_wdata_x, int_ack_x,
        output cnt_value_x, cnt_ovf_x, int_req_x
    );

endinterface

// File: rtl/ct_hpcp_int_fsm.sv
// Overflow interrupt request FSM: raises a request while ovf is set and enabled,
// and holds off after an ack until software clears ovf.
module ct_hpcp_int_fsm
    import ct_hpcp_pkg::*;
(
    input  logic hpcp_clk,
    input  logic cpurst_b,
    input  logic cnt_ovf,
    input  logic cntinten_x,
    input  logic int_ack_x,
    output logic int_req_x
);

    int_state_e state_q;
    int_state_e state_d;

    always_ff @(posedge hpcp_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            PEND: begin
                if (int_ack_x) begin
                    state_d = WAIT_CLR;
                end else if (!cnt_ovf || !cntinten_x) begin
                    // Withdrawn; re-raised from IDLE once the enable returns.
                    state_d = IDLE;
                end else begin
                    state_d = PEND;
                end
            end
            WAIT_CLR: begin
                state_d = cnt_ovf ? WAIT_CLR : IDLE;
            end
            default: begin
                state_d = (cnt_ovf && cntinten_x) ? PEND : IDLE;
            end
        endcase
    end

    // Pure decode of the state register, so no input-to-request path exists.
    assign int_req_x = (state_q == PEND);

endmodule

// File: rtl/ct_hpcp_evt_cnt.sv
// Per-counter HPCP event accumulator: one-cycle increment stage, wrapping counter,
// sticky overflow flag and gated overflow interrupt request.
module ct_hpcp_evt_cnt
    import ct_hpcp_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DFLT,
    parameter int unsigned INC_WIDTH = INC_WIDTH_DFLT
)
(
    input logic               hpcp_clk,
    input logic               cpurst_b,
    ct_hpcp_evt_cnt_if.slave  bus
);

    logic [INC_WIDTH-1:0] inc_q;
    logic [INC_WIDTH-1:0] inc_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic [CNT_WIDTH:0]   sum;
    logic                 carry;

    always_comb begin
        sum   = {1'b0, cnt_q} + {{(CNT_WIDTH + 1 - INC_WIDTH){1'b0}}, inc_q};
        cnt_d = sum[CNT_WIDTH-1:0];
        carry = 1'b0;
        inc_d = bus.cnt_en_x ? bus.evt_inc_x : '0;
        if (bus.cnt_wen_x) begin
            // Software write is exact: the staged increment and its carry are dropped.
            cnt_d = bus.hpcp_wdata_x;
            inc_d = '0;
        end else begin
            carry = sum[CNT_WIDTH];
        end

        ovf_d = ovf_q;
        if (carry) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_wen_x) begin
            ovf_d = bus.hpcp_wdata_x[0];
        end
    end

    always_ff @(posedge hpcp_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            inc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            inc_q <= inc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    ct_hpcp_int_fsm u_int_fsm (
        .hpcp_clk   (hpcp_clk),
        .cpurst_b   (cpurst_b),
        .cnt_ovf    (ovf_q),
        .cntinten_x (bus.cntinten_x),
        .int_ack_x  (bus.int_ack_x),
        .int_req_x  (bus.int_req_x)
    );

    assign bus.cnt_value_x = cnt_q;
    assign bus.cnt_ovf_x   = ovf_q;

endmodule

// File: tb/tb_ct_hpcp_evt_cnt.sv
// Directed bench for ct_hpcp_evt_cnt: counting latency, wrap/overflow, interrupt
// handshake, write priority and asynchronous reset.
module tb_ct_hpcp_evt_cnt;

    localparam int unsigned CW = 48;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic hpcp_clk;
    logic cpurst_b;
    int   n_total;
    int   n_pass;

    ct_hpcp_evt_cnt_if #(.CNT_WIDTH(CW), .INC_WIDTH(2)) bus ();

    ct_hpcp_evt_cnt #(.CNT_WIDTH(CW), .INC_WIDTH(2)) dut (
        .hpcp_clk (hpcp_clk),
        .cpurst_b (cpurst_b),
        .bus      (bus)
    );

    initial begin
        hpcp_clk = 1'b0;
        forever #5 hpcp_clk = ~hpcp_clk;
    end

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge hpcp_clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        cpurst_b          = 1'b1;
        bus.cnt_en_x      = 1'b0;
        bus.evt_inc_x     = '0;
        bus.cntinten_x    = 1'b0;
        bus.cnt_wen_x     = 1'b0;
        bus.ovf_wen_x     = 1'b0;
        bus.hpcp_wdata_x  = '0;
        bus.int_ack_x     = 1'b0;

        #2 cpurst_b = 1'b0;
        #2;
        chk("rst_cnt", bus.cnt_value_x, 48'd0);
        chk("rst_ovf", {47'd0, bus.cnt_ovf_x}, 48'd0);
        chk("rst_req", {47'd0, bus.int_req_x}, 48'd0);
        @(posedge hpcp_clk);
        #2 cpurst_b = 1'b1;

        // Four cycles of 3 events, visible two edges later, plus drain.
        bus.cnt_en_x  = 1'b1;
        bus.evt_inc_x = 2'd3;
        step(); chk("cnt_lat0", bus.cnt_value_x, 48'd0);
        step(); chk("cnt_3", bus.cnt_value_x, 48'd3);
        step(); chk("cnt_6", bus.cnt_value_x, 48'd6);
        step(); chk("cnt_9", bus.cnt_value_x, 48'd9);
        bus.cnt_en_x = 1'b0;
        step(); chk("cnt_drain_12", bus.cnt_value_x, 48'd12);
        step(); chk("cnt_hold_12", bus.cnt_value_x, 48'd12);

        // Wrap from max-1 by 3.
        bus.cnt_wen_x    = 1'b1;
        bus.hpcp_wdata_x = CNT_MAX - 48'd1;
        step();
        bus.cnt_wen_x = 1'b0;
        chk("wr_max_m1", bus.cnt_value_x, CNT_MAX - 48'd1);
        bus.cnt_en_x  = 1'b1;
        bus.evt_inc_x = 2'd3;
        step();
        bus.cnt_en_x = 1'b0;
        chk("pre_wrap_ovf", {47'd0, bus.cnt_ovf_x}, 48'd0);
        step();
        chk("wrap_cnt", bus.cnt_value_x, 48'd1);
        chk("wrap_ovf", {47'd0, bus.cnt_ovf_x}, 48'd1);
        chk("wrap_noint", {47'd0, bus.int_req_x}, 48'd0);
        bus.cntinten_x = 1'b1;
        step(); chk("int_raise", {47'd0, bus.int_req_x}, 48'd1);

        // Ack, then no re-request until software clears ovf.
        bus.int_ack_x = 1'b1;
        step();
        bus.int_ack_x = 1'b0;
        chk("ack_drop", {47'd0, bus.int_req_x}, 48'd0);
        step(); step();
        chk("wait_clr_hold", {47'd0, bus.int_req_x}, 48'd0);
        bus.ovf_wen_x    = 1'b1;
        bus.hpcp_wdata_x = '0;
        step();
        bus.ovf_wen_x = 1'b0;
        chk("sw_clr_ovf", {47'd0, bus.cnt_ovf_x}, 48'd0);
        step(); chk("idle_after_clr", {47'd0, bus.int_req_x}, 48'd0);
        bus.cnt_wen_x    = 1'b1;
        bus.hpcp_wdata_x = CNT_MAX;
        step();
        bus.cnt_wen_x = 1'b0;
        bus.cnt_en_x  = 1'b1;
        bus.evt_inc_x = 2'd1;
        step();
        bus.cnt_en_x = 1'b0;
        step();
        chk("wrap2_cnt", bus.cnt_value_x, 48'd0);
        chk("wrap2_ovf", {47'd0, bus.cnt_ovf_x}, 48'd1);
        step(); chk("int_reraise", {47'd0, bus.int_req_x}, 48'd1);

        // Enable withdrawn while pending, then restored.
        bus.cntinten_x = 1'b0;
        step(); chk("inten_drop", {47'd0, bus.int_req_x}, 48'd0);
        step(); chk("inten_off_hold", {47'd0, bus.int_req_x}, 48'd0);
        bus.cntinten_x = 1'b1;
        step(); chk("inten_back", {47'd0, bus.int_req_x}, 48'd1);

        // Counter write beats an in-flight increment of 2.
        bus.cnt_en_x  = 1'b1;
        bus.evt_inc_x = 2'd2;
        step();
        bus.cnt_en_x     = 1'b0;
        bus.cnt_wen_x    = 1'b1;
        bus.hpcp_wdata_x = 48'h100;
        step();
        bus.cnt_wen_x = 1'b0;
        chk("wen_exact", bus.cnt_value_x, 48'h100);
        step(); chk("wen_inc_lost", bus.cnt_value_x, 48'h100);
        chk("wen_keeps_ovf", {47'd0, bus.cnt_ovf_x}, 48'd1);

        // Carry and software clear on the same edge: set wins.
        bus.ovf_wen_x    = 1'b1;
        bus.hpcp_wdata_x = '0;
        step();
        bus.ovf_wen_x = 1'b0;
        chk("clr_before_race", {47'd0, bus.cnt_ovf_x}, 48'd0);
        bus.cnt_wen_x    = 1'b1;
        bus.hpcp_wdata_x = CNT_MAX;
        step();
        bus.cnt_wen_x = 1'b0;
        chk("wr_max", bus.cnt_value_x, CNT_MAX);
        bus.cnt_en_x  = 1'b1;
        bus.evt_inc_x = 2'd1;
        step();
        bus.cnt_en_x     = 1'b0;
        bus.ovf_wen_x    = 1'b1;
        bus.hpcp_wdata_x = '0;
        step();
        bus.ovf_wen_x = 1'b0;
        chk("race_ovf_set", {47'd0, bus.cnt_ovf_x}, 48'd1);
        chk("race_cnt", bus.cnt_value_x, 48'd0);
        // Ack held while IDLE must not block the new request.
        bus.int_ack_x = 1'b1;
        step(); chk("ack_idle_ignored", {47'd0, bus.int_req_x}, 48'd1);
        step();
        bus.int_ack_x = 1'b0;
        chk("ack_in_pend", {47'd0, bus.int_req_x}, 48'd0);

        // Asynchronous reset mid-count, then restart latency.
        bus.cnt_en_x  = 1'b1;
        bus.evt_inc_x = 2'd3;
        step(); step();
        chk("pre_rst_cnt", bus.cnt_value_x, 48'd3);
        #3 cpurst_b = 1'b0;
        #1;
        chk("arst_cnt", bus.cnt_value_x, 48'd0);
        chk("arst_ovf", {47'd0, bus.cnt_ovf_x}, 48'd0);
        chk("arst_req", {47'd0, bus.int_req_x}, 48'd0);
        #2 cpurst_b = 1'b1;
        step(); chk("post_rst_lat", bus.cnt_value_x, 48'd0);
        step(); chk("post_rst_first", bus.cnt_value_x, 48'd3);
        bus.cnt_en_x = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
